alu_writeback: RTL and testbench
================================

// Module: alu_writeback
// PURPOSE
//  Result/flag commit stage at the output end of the bitwise ALU. Accepts {result, carry} with
//  valid/ready, buffers up to 2 entries, masks result to operand size, writes the register file
//  under ack, and owns the architectural carry/zero/sign flags. o_carry drives the ALU's i_carry.
// PARAMETERS
//  REG_IDX_W   5   width of destination register index
//  DEPTH       2   buffer entries (fixed 2; other values unsupported)
// PORTS
//  i_clk        in   1          single clock; all state on rising edge
//  i_reset      in   1          synchronous, active-high reset
//  i_valid      in   1          ALU result valid
//  o_ready      out  1          stage can accept an entry
//  i_result     in   64         ALU result (long_t)
//  i_carry      in   1          ALU carry out
//  i_size       in   2          arg_size_t: BYTES_8/16/32/64
//  i_dest       in   REG_IDX_W  destination register
//  i_set_carry  in   1          instr had USE_CARRY_BIT; commit updates carry flag
//  i_flush      in   1          discard all uncommitted entries
//  o_wr_en      out  1          regfile write request (head valid)
//  o_wr_idx     out  REG_IDX_W  write index
//  o_wr_data    out  64         masked write data
//  i_wr_ack     in   1          regfile accepted write this cycle
//  o_carry      out  1          committed carry flag
//  o_carry_busy out  1          some buffered entry has set_carry=1
//  o_zero       out  1          committed zero flag
//  o_sign       out  1          committed sign flag
// BEHAVIOUR
//  - Reset: count=0, o_wr_en=0, o_carry=0, o_zero=0, o_sign=0, o_carry_busy=0; entries dropped,
//    including any reset arriving mid-operation.
//  - o_ready = (count<2) && !i_flush. Push when i_valid && o_ready. No bypass: entry pushed in cycle
//    N appears on o_wr_* at N+1 earliest (min latency 1 cycle).
//  - o_wr_en = (count!=0); o_wr_idx/o_wr_data from head, stable while o_wr_en && !i_wr_ack.
//  - Pop when o_wr_en && i_wr_ack. Push+pop same cycle: count unchanged, order preserved.
//  - Full (count=2) with pop: ready stays low that cycle; no push.
//  - Masking on push: data zero-extended above size (8/16/32/64 bits); 64-bit passes unmasked.
//  - On pop: o_zero <= (masked==0); o_sign <= masked[size_bits-1];
//    o_carry <= head.carry only if head.set_carry, else held.
//  - o_carry_busy combinational OR of set_carry over valid entries; issue stalls carry consumers.
//  - i_flush: head write acked in the flush cycle commits (regfile+flags); all other entries and
//    any push that cycle dropped; count=0 next cycle. Flags otherwise unchanged by flush.
//  - i_wr_ack while o_wr_en=0 ignored.
// STRUCTURE
//  - types pkg: wb_entry_t {long_t data; logic carry; logic set_carry; arg_size_t size; dest}.
//  - types pkg: function size_mask(arg_size_t) -> long_t; function sign_bit(long_t, arg_size_t).
//  - Sub-module wb_fifo: 2-entry synchronous FIFO of wb_entry_t with push/pop/flush, count,
//    per-entry valid vector exported for o_carry_busy.
//  - Top: masking on push, flag registers, handshake glue.
// TESTING
//  1 Reset, then i_valid, result=64'h1FF, size=BYTES_8, dest=3, ack=1 -> next cycle wr_en, idx=3,
//    data=64'hFF; after pop zero=0, sign=1.
//  2 Push result=0, size=BYTES_64, set_carry=1, carry=1 -> on commit zero=1, sign=0, carry=1;
//    carry_busy=1 only while buffered.
//  3 Hold ack=0, push 3 back-to-back -> ready low after 2nd; 3rd held by source; ack=1 drains in
//    push order A,B,C, data stable while stalled.
//  4 count=1, simultaneous push+pop for 4 cycles -> count stays 1, one write per cycle, in order.
//  5 count=2, ack=1 with flush -> head committed, 2nd dropped, push that cycle dropped; wr_en=0 next.
//  6 Reset asserted with count=2, carry=1 -> next cycle all outputs at reset values, no write.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// Shared types and helpers for the ALU result/flag commit stage.
//   long_t      : 64-bit ALU datapath word
//   arg_size_t  : operand size selector (8/16/32/64 bits)
//   wb_entry_t  : one buffered commit entry
//   size_mask() : low-bit mask for an operand size
//   sign_bit()  : most significant bit of a value at an operand size
package alu_writeback_pkg;

  typedef logic [63:0] long_t;

  typedef enum logic [1:0] {
    BYTES_8  = 2'd0,
    BYTES_16 = 2'd1,
    BYTES_32 = 2'd2,
    BYTES_64 = 2'd3
  } arg_size_t;

  // Destination index width carried inside a buffered entry.
  localparam int DEST_W = 5;

  // Number of buffer entries; the FIFO pointer logic assumes exactly 2.
  localparam int WB_DEPTH = 2;

  typedef struct packed {
    long_t              data;
    logic               carry;
    logic               set_carry;
    arg_size_t          size;
    logic [DEST_W-1:0]  dest;
  } wb_entry_t;

  function automatic long_t size_mask(input arg_size_t size);
    long_t mask;
    case (size)
      BYTES_8:  mask = 64'h0000_0000_0000_00FF;
      BYTES_16: mask = 64'h0000_0000_0000_FFFF;
      BYTES_32: mask = 64'h0000_0000_FFFF_FFFF;
      default:  mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return mask;
  endfunction

  function automatic logic sign_bit(input long_t data, input arg_size_t size);
    logic sign;
    case (size)
      BYTES_8:  sign = data[7];
      BYTES_16: sign = data[15];
      BYTES_32: sign = data[31];
      default:  sign = data[63];
    endcase
    return sign;
  endfunction

endpackage

// File: rtl/alu_writeback_wb_fifo.sv
// Two-entry synchronous FIFO of commit entries.
//   clk, reset     : clock, synchronous active-high reset
//   push, din      : enqueue din (ignored when full)
//   pop            : dequeue head (ignored when empty)
//   flush          : drop every entry; wins over push/pop
//   head           : oldest entry (meaningful while count != 0)
//   count          : occupancy 0..2
//   valid          : per-slot occupancy vector
//   set_carry_vec  : per-slot set_carry bit (qualify with valid)
module wb_fifo
  import alu_writeback_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  wb_entry_t           din,
  output wb_entry_t           head,
  output logic [1:0]          count,
  output logic [WB_DEPTH-1:0] valid,
  output logic [WB_DEPTH-1:0] set_carry_vec
);

  wb_entry_t  mem [WB_DEPTH];
  logic       rd_ptr;
  logic       wr_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);

  // Storage carries no reset: slots are only read while marked valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // With one entry only the read slot is live; with two both are.
  always_comb begin
    valid = '0;
    if (count == 2'd2) begin
      valid = '1;
    end else if (count == 2'd1) begin
      valid[rd_ptr] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < WB_DEPTH; i++) begin
      set_carry_vec[i] = mem[i].set_carry;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// Result/flag commit stage at the output of the bitwise ALU.
// Accepts {result, carry} with valid/ready, buffers up to two entries, masks
// the result to the operand size, writes the register file under ack and owns
// the architectural carry/zero/sign flags (o_carry feeds the ALU's i_carry).
//
// Handshake: an entry is taken on a rising edge where i_valid && o_ready;
// o_ready = (count < 2) && !i_flush and does not depend on i_wr_ack, so a full
// buffer refuses a push even in a cycle where it pops. A write retires on a
// rising edge where o_wr_en && i_wr_ack; o_wr_idx/o_wr_data hold until then.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_valid, o_ready          upstream handshake
//   i_result, i_carry         ALU result and carry out
//   i_size                    operand size (arg_size_t encoding)
//   i_dest                    destination register index
//   i_set_carry               commit of this entry updates the carry flag
//   i_flush                   drop all uncommitted entries
//   o_wr_en, o_wr_idx,
//   o_wr_data, i_wr_ack       register-file write port
//   o_carry, o_zero, o_sign   committed flags
//   o_carry_busy              a buffered entry will still update carry
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int REG_IDX_W = DEST_W
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [63:0]          i_result,
  input  logic                 i_carry,
  input  logic [1:0]           i_size,
  input  logic [REG_IDX_W-1:0] i_dest,
  input  logic                 i_set_carry,
  input  logic                 i_flush,
  output logic                 o_wr_en,
  output logic [REG_IDX_W-1:0] o_wr_idx,
  output logic [63:0]          o_wr_data,
  input  logic                 i_wr_ack,
  output logic                 o_carry,
  output logic                 o_carry_busy,
  output logic                 o_zero,
  output logic                 o_sign
);

  logic                push;
  logic                pop;
  wb_entry_t           din;
  wb_entry_t           head;
  logic [1:0]          count;
  logic [WB_DEPTH-1:0] valid;
  logic [WB_DEPTH-1:0] set_carry_vec;

  assign o_ready = (count != 2'd2) && !i_flush;
  assign push    = i_valid && o_ready;
  assign o_wr_en = (count != 2'd0);
  assign pop     = o_wr_en && i_wr_ack;

  // Masking happens before storage so the head is already the final write data.
  always_comb begin
    din.size      = arg_size_t'(i_size);
    din.data      = i_result & size_mask(arg_size_t'(i_size));
    din.carry     = i_carry;
    din.set_carry = i_set_carry;
    din.dest      = i_dest;
  end

  wb_fifo u_fifo (
    .clk           (i_clk),
    .reset         (i_reset),
    .push          (push),
    .pop           (pop),
    .flush         (i_flush),
    .din           (din),
    .head          (head),
    .count         (count),
    .valid         (valid),
    .set_carry_vec (set_carry_vec)
  );

  assign o_wr_idx  = head.dest;
  assign o_wr_data = head.data;

  // A head acked in a flush cycle still commits: pop is not gated by flush.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_carry <= 1'b0;
      o_zero  <= 1'b0;
      o_sign  <= 1'b0;
    end else if (pop) begin
      o_zero <= (head.data == 64'd0);
      o_sign <= sign_bit(head.data, head.size);
      if (head.set_carry) begin
        o_carry <= head.carry;
      end
    end
  end

  assign o_carry_busy = |(valid & set_carry_vec);

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

  typedef struct packed {
    logic [63:0] data;
    logic        carry;
    logic        set_carry;
    logic [1:0]  size;
    logic [4:0]  dest;
  } exp_t;

  logic        clk;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] i_result;
  logic        i_carry;
  logic [1:0]  i_size;
  logic [4:0]  i_dest;
  logic        i_set_carry;
  logic        i_flush;
  logic        o_wr_en;
  logic [4:0]  o_wr_idx;
  logic [63:0] o_wr_data;
  logic        i_wr_ack;
  logic        o_carry;
  logic        o_carry_busy;
  logic        o_zero;
  logic        o_sign;

  // Scoreboard: exp_q mirrors entries resident in the stage, new_q holds
  // entries accepted by the upcoming edge (merged by the monitor).
  exp_t exp_q[$];
  exp_t new_q[$];
  logic m_carry, m_zero, m_sign;
  logic mon_en;
  int   n_checks;
  int   n_fail;

  alu_writeback #(.REG_IDX_W(5)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_result     (i_result),
    .i_carry      (i_carry),
    .i_size       (i_size),
    .i_dest       (i_dest),
    .i_set_carry  (i_set_carry),
    .i_flush      (i_flush),
    .o_wr_en      (o_wr_en),
    .o_wr_idx     (o_wr_idx),
    .o_wr_data    (o_wr_data),
    .i_wr_ack     (i_wr_ack),
    .o_carry      (o_carry),
    .o_carry_busy (o_carry_busy),
    .o_zero       (o_zero),
    .o_sign       (o_sign)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference helpers ----------------
  function automatic int size_bits(input logic [1:0] sz);
    return 8 << int'(sz);
  endfunction

  function automatic logic [63:0] ref_mask(input logic [1:0] sz);
    logic [63:0] one;
    one = 64'd1;
    if (size_bits(sz) == 64) return '1;
    return (one << size_bits(sz)) - 64'd1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [63:0] r, input logic [1:0] sz,
                       input logic [4:0] d, input logic sc, input logic c,
                       input logic ack, input logic fl, input logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    i_valid     = v;
    i_result    = r;
    i_size      = sz;
    i_dest      = d;
    i_set_carry = sc;
    i_carry     = c;
    i_wr_ack    = ack;
    i_flush     = fl;
    i_reset     = rst;
    if (!rst && v && !fl && exp_q.size() < 2) begin
      e.data      = r & ref_mask(sz);
      e.carry     = c;
      e.set_carry = sc;
      e.size      = sz;
      e.dest      = d;
      new_q.push_back(e);
    end
  endtask

  task automatic idle(input logic ack);
    drive(1'b0, 64'h0, 2'd0, 5'd0, 1'b0, 1'b0, ack, 1'b0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t h;
    logic busy;
    int   n;
    forever begin
      @(posedge clk);
      #2;
      n = exp_q.size();
      if (mon_en) begin
        check("wr_en", o_wr_en, n != 0);
        check("ready", o_ready, (n < 2) && !i_flush);
        busy = 1'b0;
        foreach (exp_q[k]) busy |= exp_q[k].set_carry;
        check("carry_busy", o_carry_busy, busy);
        check("zero", o_zero, m_zero);
        check("sign", o_sign, m_sign);
        check("carry", o_carry, m_carry);
        if (n != 0) begin
          check("wr_idx", o_wr_idx, exp_q[0].dest);
          check("wr_data", o_wr_data, exp_q[0].data);
        end
      end
      if (i_reset) begin
        exp_q.delete();
        new_q.delete();
        m_carry = 1'b0;
        m_zero  = 1'b0;
        m_sign  = 1'b0;
      end else begin
        if (n != 0 && i_wr_ack) begin
          h = exp_q.pop_front();
          m_zero = (h.data == 64'd0);
          m_sign = h.data[size_bits(h.size) - 1];
          if (h.set_carry) m_carry = h.carry;
        end
        if (i_flush) exp_q.delete();
        while (new_q.size() != 0) exp_q.push_back(new_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] r;
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    m_carry  = 1'b0;
    m_zero   = 1'b0;
    m_sign   = 1'b0;
    i_reset  = 1'b1;
    i_valid  = 1'b0;
    i_result = '0;
    i_size   = '0;
    i_dest   = '0;
    i_set_carry = 1'b0;
    i_carry  = 1'b0;
    i_wr_ack = 1'b0;
    i_flush  = 1'b0;

    repeat (2) drive(1'b0, 64'h0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;

    // 1: byte masking, sign from bit 7
    drive(1'b1, 64'h1FF, 2'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) idle(1'b1);

    // 2: zero result with carry update; busy while buffered
    drive(1'b1, 64'h0, 2'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) idle(1'b0);
    repeat (3) idle(1'b1);

    // 3: stalled sink, third push held by source until space
    drive(1'b1, 64'hAAAA_0000_1234_8001, 2'd1, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'h5555_0000_8000_0000, 2'd2, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 2'd3, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 2'd3, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) idle(1'b1);

    // 4: steady state push+pop at count=1
    drive(1'b1, 64'h80, 2'd0, 5'd20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      drive(1'b1, 64'h100 * (i + 1), 2'd1, 5'(21 + i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) idle(1'b1);

    // 5: flush at count=2 with ack: head commits, rest and new push dropped
    drive(1'b1, 64'h8000, 2'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'h0, 2'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'h77, 2'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) idle(1'b0);

    // 6: reset with two entries buffered and carry set
    drive(1'b1, 64'h1, 2'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'h2, 2'd3, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'h3, 2'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'h4, 2'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (2) idle(1'b1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      r = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) r[31:0] = 32'h0;
      if ($urandom_range(0, 7) == 0) r = 64'h0;
      drive(1'($urandom_range(0, 1)), r, 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    end
    repeat (4) idle(1'b1);

    @(posedge clk);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
